slot_sched_table: RTL and testbench

SLOT_SCHED_TABLE -- requirements
Module: slot_sched_table

---
 rtl/slot_sched_table_if.sv | 51 +++++
 rtl/slot_sched_table.sv | 238 +++++++++++++++++++++++
 tb/tb_slot_sched_table.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/slot_sched_table_if.sv
// Host register-access, issue-handshake and sequencer-control bundle for slot_sched_table.
// The master side is the host/engine; the slave side is the scheduler table.
interface slot_sched_table_if #(
   parameter int INDEX_WIDTH = 3,
   parameter int ADDR_WIDTH  = 32,
   parameter int SIZE_WIDTH  = 26,
   parameter int MSK_WIDTH   = 8,
   parameter int DATA_WIDTH  = 32
);
   logic                   wr_en;
   logic [INDEX_WIDTH-1:0] wr_index;
   logic [2:0]             wr_field;
   logic [DATA_WIDTH-1:0]  wr_data;
   logic                   wr_err;
   logic                   rd_en;
   logic [INDEX_WIDTH-1:0] rd_index;
   logic [2:0]             rd_field;
   logic [DATA_WIDTH-1:0]  rd_data;
   logic                   rd_valid;
   logic                   start;
   logic [INDEX_WIDTH-1:0] start_index;
   logic                   abort;
   logic                   iss_valid;
   logic                   iss_ready;
   logic [ADDR_WIDTH-1:0]  iss_src_addr;
   logic [SIZE_WIDTH-1:0]  iss_src_size;
   logic [ADDR_WIDTH-1:0]  iss_des_addr;
   logic [SIZE_WIDTH-1:0]  iss_des_size;
   logic [MSK_WIDTH-1:0]   iss_ld_mask;
   logic [MSK_WIDTH-1:0]   iss_st_mask;
   logic [INDEX_WIDTH-1:0] iss_index;
   logic                   eng_done;
   logic                   busy;
   logic                   seq_done;

   modport master (
      output wr_en, wr_index, wr_field, wr_data, rd_en, rd_index, rd_field,
             start, start_index, abort, iss_ready, eng_done,
      input  wr_err, rd_data, rd_valid, iss_valid, iss_src_addr, iss_src_size,
             iss_des_addr, iss_des_size, iss_ld_mask, iss_st_mask, iss_index,
             busy, seq_done
   );

   modport slave (
      input  wr_en, wr_index, wr_field, wr_data, rd_en, rd_index, rd_field,
             start, start_index, abort, iss_ready, eng_done,
      output wr_err, rd_data, rd_valid, iss_valid, iss_src_addr, iss_src_size,
             iss_des_addr, iss_des_size, iss_ld_mask, iss_st_mask, iss_index,
             busy, seq_done
   );
endinterface

// File: rtl/slot_sched_table.sv
// Slot descriptor table with host read/write access and a sequencer that walks slots
// from a start index, issues READY slots to an engine and profiles their run time.
module slot_sched_table #(
   parameter int INDEX_WIDTH   = 3,
   parameter int ADDR_WIDTH    = 32,
   parameter int SIZE_WIDTH    = 26,
   parameter int PROFILE_WIDTH = 32,
   parameter int MSK_WIDTH     = 8,
   parameter int DATA_WIDTH    = 32
) (
   input logic               clk,
   input logic               reset,
   slot_sched_table_if.slave bus
);
   localparam int SLOTS = 1 << INDEX_WIDTH;
   localparam logic [INDEX_WIDTH:0] VIS_FULL = (INDEX_WIDTH+1)'(SLOTS);
   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_READY   = 2'd1;
   localparam logic [1:0] ST_RUNNING = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SCAN   = 3'd1,
      S_ISSUE  = 3'd2,
      S_WAIT   = 3'd3,
      S_FINISH = 3'd4
   } state_e;

   state_e                   state_q, state_d;
   logic [INDEX_WIDTH-1:0]   ptr_q, ptr_d, ptr_inc_s;
   logic [INDEX_WIDTH:0]     visited_q, visited_d, vis_inc_s;
   logic [PROFILE_WIDTH-1:0] cnt_q, cnt_d, cnt_inc_s;

   logic [ADDR_WIDTH-1:0]    src_addr_q [SLOTS];
   logic [SIZE_WIDTH-1:0]    src_size_q [SLOTS];
   logic [ADDR_WIDTH-1:0]    des_addr_q [SLOTS];
   logic [SIZE_WIDTH-1:0]    des_size_q [SLOTS];
   logic [1:0]               status_q   [SLOTS];
   logic [MSK_WIDTH-1:0]     ld_mask_q  [SLOTS];
   logic [MSK_WIDTH-1:0]     st_mask_q  [SLOTS];
   logic [PROFILE_WIDTH-1:0] profile_q  [SLOTS];

   logic                     set_running_s, set_ready_s, set_done_s, wr_block_s;
   logic [DATA_WIDTH-1:0]    rd_mux_s;
   logic                     wr_err_q, rd_valid_q, iss_valid_q, busy_q, seq_done_q;
   logic [DATA_WIDTH-1:0]    rd_data_q;
   logic [ADDR_WIDTH-1:0]    iss_src_addr_q, iss_des_addr_q;
   logic [SIZE_WIDTH-1:0]    iss_src_size_q, iss_des_size_q;
   logic [MSK_WIDTH-1:0]     iss_ld_mask_q, iss_st_mask_q;
   logic [INDEX_WIDTH-1:0]   iss_index_q;

   assign ptr_inc_s = ptr_q + INDEX_WIDTH'(1);
   assign vis_inc_s = visited_q + (INDEX_WIDTH+1)'(1);
   assign cnt_inc_s = (cnt_q == {PROFILE_WIDTH{1'b1}}) ? cnt_q : cnt_q + PROFILE_WIDTH'(1);
   // The slot owned by the engine cannot be modified by the host.
   assign wr_block_s = bus.wr_en && (bus.wr_index == ptr_q) &&
                       ((state_q == S_ISSUE) || (state_q == S_WAIT));

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      visited_d     = visited_q;
      cnt_d         = cnt_q;
      set_running_s = 1'b0;
      set_ready_s   = 1'b0;
      set_done_s    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d   = S_SCAN;
               ptr_d     = bus.start_index;
               visited_d = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SCAN: begin
            if (bus.abort) begin
               state_d = S_FINISH;
            end else begin
               case (status_q[ptr_q])
                  ST_READY: begin
                     state_d       = S_ISSUE;
                     set_running_s = 1'b1;
                  end
                  ST_EMPTY: state_d = S_FINISH;
                  default: begin
                     ptr_d     = ptr_inc_s;
                     visited_d = vis_inc_s;
                     state_d   = (vis_inc_s == VIS_FULL) ? S_FINISH : S_SCAN;
                  end
               endcase
            end
         end
         S_ISSUE: begin
            if (bus.abort) begin
               state_d     = S_FINISH;
               set_ready_s = 1'b1;
            end else if (bus.iss_ready) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_WAIT: begin
            if (bus.abort) begin
               state_d     = S_FINISH;
               set_ready_s = 1'b1;
            end else if (bus.eng_done) begin
               set_done_s = 1'b1;
               ptr_d      = ptr_inc_s;
               visited_d  = vis_inc_s;
               state_d    = (vis_inc_s == VIS_FULL) ? S_FINISH : S_SCAN;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_mux_s = '0;
      case (bus.rd_field)
         3'd0:    rd_mux_s = DATA_WIDTH'(src_addr_q[bus.rd_index]);
         3'd1:    rd_mux_s = DATA_WIDTH'(src_size_q[bus.rd_index]);
         3'd2:    rd_mux_s = DATA_WIDTH'(des_addr_q[bus.rd_index]);
         3'd3:    rd_mux_s = DATA_WIDTH'(des_size_q[bus.rd_index]);
         3'd4:    rd_mux_s = DATA_WIDTH'(status_q[bus.rd_index]);
         3'd5:    rd_mux_s = DATA_WIDTH'(ld_mask_q[bus.rd_index]);
         3'd6:    rd_mux_s = DATA_WIDTH'(st_mask_q[bus.rd_index]);
         3'd7:    rd_mux_s = DATA_WIDTH'(profile_q[bus.rd_index]);
         default: rd_mux_s = '0;
      endcase
   end

   // Sequencer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         visited_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         visited_q <= visited_d;
         cnt_q     <= cnt_d;
      end
   end

   // Slot storage; sequencer status updates override a same-cycle host write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SLOTS; i++) begin
            src_addr_q[i] <= '0;
            src_size_q[i] <= '0;
            des_addr_q[i] <= '0;
            des_size_q[i] <= '0;
            status_q[i]   <= ST_EMPTY;
            ld_mask_q[i]  <= '0;
            st_mask_q[i]  <= '0;
            profile_q[i]  <= '0;
         end
      end else begin
         if (bus.wr_en && !wr_block_s) begin
            case (bus.wr_field)
               3'd0:    src_addr_q[bus.wr_index] <= bus.wr_data[ADDR_WIDTH-1:0];
               3'd1:    src_size_q[bus.wr_index] <= bus.wr_data[SIZE_WIDTH-1:0];
               3'd2:    des_addr_q[bus.wr_index] <= bus.wr_data[ADDR_WIDTH-1:0];
               3'd3:    des_size_q[bus.wr_index] <= bus.wr_data[SIZE_WIDTH-1:0];
               3'd4:    status_q[bus.wr_index]   <= bus.wr_data[1:0];
               3'd5:    ld_mask_q[bus.wr_index]  <= bus.wr_data[MSK_WIDTH-1:0];
               3'd6:    st_mask_q[bus.wr_index]  <= bus.wr_data[MSK_WIDTH-1:0];
               default: ;
            endcase
         end
         if (set_running_s) status_q[ptr_q] <= ST_RUNNING;
         if (set_ready_s)   status_q[ptr_q] <= ST_READY;
         if (set_done_s) begin
            status_q[ptr_q]  <= ST_DONE;
            profile_q[ptr_q] <= cnt_inc_s;
         end
      end
   end

   // Registered host and engine-facing outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_err_q       <= 1'b0;
         rd_valid_q     <= 1'b0;
         rd_data_q      <= '0;
         iss_valid_q    <= 1'b0;
         busy_q         <= 1'b0;
         seq_done_q     <= 1'b0;
         iss_src_addr_q <= '0;
         iss_src_size_q <= '0;
         iss_des_addr_q <= '0;
         iss_des_size_q <= '0;
         iss_ld_mask_q  <= '0;
         iss_st_mask_q  <= '0;
         iss_index_q    <= '0;
      end else begin
         wr_err_q    <= wr_block_s;
         rd_valid_q  <= bus.rd_en;
         if (bus.rd_en) rd_data_q <= rd_mux_s;
         iss_valid_q <= (state_d == S_ISSUE);
         busy_q      <= (state_d != S_IDLE);
         seq_done_q  <= (state_q == S_FINISH);
         if (set_running_s) begin
            iss_src_addr_q <= src_addr_q[ptr_q];
            iss_src_size_q <= src_size_q[ptr_q];
            iss_des_addr_q <= des_addr_q[ptr_q];
            iss_des_size_q <= des_size_q[ptr_q];
            iss_ld_mask_q  <= ld_mask_q[ptr_q];
            iss_st_mask_q  <= st_mask_q[ptr_q];
            iss_index_q    <= ptr_q;
         end
      end
   end

   assign bus.wr_err       = wr_err_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_data      = rd_data_q;
   assign bus.iss_valid    = iss_valid_q;
   assign bus.busy         = busy_q;
   assign bus.seq_done     = seq_done_q;
   assign bus.iss_src_addr = iss_src_addr_q;
   assign bus.iss_src_size = iss_src_size_q;
   assign bus.iss_des_addr = iss_des_addr_q;
   assign bus.iss_des_size = iss_des_size_q;
   assign bus.iss_ld_mask  = iss_ld_mask_q;
   assign bus.iss_st_mask  = iss_st_mask_q;
   assign bus.iss_index    = iss_index_q;
endmodule

// File: tb/tb_slot_sched_table.sv
// Self-checking bench for slot_sched_table: register access, sequencing order,
// profiling, write rejection, abort and mid-sequence reset.
module tb_slot_sched_table;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_checks = 0;
   int n_fail = 0;
   logic [2:0]  iss_q[$];
   logic [31:0] rd_q[$];

   slot_sched_table_if #(.INDEX_WIDTH(3), .ADDR_WIDTH(32), .SIZE_WIDTH(26),
                         .MSK_WIDTH(8), .DATA_WIDTH(32)) bus ();

   slot_sched_table #(.INDEX_WIDTH(3), .ADDR_WIDTH(32), .SIZE_WIDTH(26), .PROFILE_WIDTH(32),
                      .MSK_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic do_write(input logic [2:0] idx, input logic [2:0] fld, input logic [31:0] data);
      bus.wr_en = 1'b1; bus.wr_index = idx; bus.wr_field = fld; bus.wr_data = data;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic do_read(input logic [2:0] idx, input logic [2:0] fld, input logic [31:0] exp_v,
                          input string name);
      logic [31:0] e;
      rd_q.push_back(exp_v);
      bus.rd_en = 1'b1; bus.rd_index = idx; bus.rd_field = fld;
      @(negedge clk);
      bus.rd_en = 1'b0;
      e = rd_q.pop_front();
      n_checks++;
      if (bus.rd_valid !== 1'b1) begin
         n_fail++; $display("FAIL %s_valid slot %0d: got %b, expected 1", name, idx, bus.rd_valid);
      end
      n_checks++;
      if (bus.rd_data !== e) begin
         n_fail++; $display("FAIL %s slot %0d field %0d: got %h, expected %h", name, idx, fld, bus.rd_data, e);
      end
   endtask

   task automatic start_seq(input logic [2:0] idx);
      bus.start = 1'b1; bus.start_index = idx;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_issue(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.iss_valid === 1'b1) ok = 1'b1;
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL wait_issue: iss_valid still 0 after 20 cycles, expected 1"); end
   endtask

   // Engine model: accepts every issue, checks it against the expected order and
   // pulses eng_done 'delay' cycles after the handshake.
   task automatic run_engine(input int delay, input int budget, output int n_seq);
      int cyc = 0;
      int wait_cnt = 0;
      bit finished = 1'b0;
      logic [2:0] e;
      n_seq = 0;
      while (!finished && cyc < budget) begin
         @(negedge clk); cyc++;
         bus.eng_done = 1'b0;
         if (bus.seq_done === 1'b1) begin n_seq++; finished = 1'b1; end
         if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) bus.eng_done = 1'b1;
         end else if (bus.iss_valid === 1'b1 && bus.iss_ready === 1'b1) begin
            n_checks++;
            if (iss_q.size() == 0) begin
               n_fail++; $display("FAIL issue_extra: got index %0d, expected no further issue", bus.iss_index);
            end else begin
               e = iss_q.pop_front();
               if (bus.iss_index !== e) begin
                  n_fail++; $display("FAIL issue_order: got index %0d, expected %0d", bus.iss_index, e);
               end
               n_checks++;
               if (bus.iss_src_addr !== 32'h100 + 32'(e)) begin
                  n_fail++; $display("FAIL issue_desc: got src_addr %h, expected %h", bus.iss_src_addr, 32'h100 + 32'(e));
               end
            end
            wait_cnt = delay;
         end
      end
      bus.eng_done = 1'b0;
      n_checks++;
      if (!finished) begin n_fail++; $display("FAIL engine_timeout: seq_done not seen in %0d cycles, expected 1", budget); end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
      n_checks++; if (bus.iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %b, expected 0", bus.iss_valid); end
      n_checks++; if (bus.seq_done !== 1'b0) begin n_fail++; $display("FAIL reset_seq_done: got %b, expected 0", bus.seq_done); end
      n_checks++; if (bus.wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %b, expected 0", bus.wr_err); end
      n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b, expected 0", bus.rd_valid); end
      n_checks++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h, expected 0", bus.rd_data); end
      n_checks++; if (bus.iss_src_addr !== 32'h0) begin n_fail++; $display("FAIL reset_iss_src_addr: got %h, expected 0", bus.iss_src_addr); end
      for (int i = 0; i < 8; i++) do_read(3'(i), 3'd4, 32'd0, "reset_status");
      do_read(3'd7, 3'd7, 32'd0, "reset_profile");
   endtask

   task automatic test_write_read();
      logic [31:0] held;
      do_write(3'd2, 3'd0, 32'h1000_0040);
      do_read(3'd2, 3'd0, 32'h1000_0040, "rd_src_addr");
      held = 32'h1000_0040;
      @(negedge clk);
      n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_drop: got %b, expected 0", bus.rd_valid); end
      n_checks++; if (bus.rd_data !== held) begin n_fail++; $display("FAIL rd_data_hold: got %h, expected %h", bus.rd_data, held); end
      do_write(3'd5, 3'd1, 32'hFFFF_FFFF);
      do_read(3'd5, 3'd1, 32'h03FF_FFFF, "rd_src_size_trunc");
      do_write(3'd5, 3'd5, 32'h0000_01A5);
      do_read(3'd5, 3'd5, 32'h0000_00A5, "rd_ld_mask");
      do_write(3'd6, 3'd6, 32'h0000_FF3C);
      do_read(3'd6, 3'd6, 32'h0000_003C, "rd_st_mask");
      do_write(3'd6, 3'd2, 32'hDEAD_BEEF);
      do_read(3'd6, 3'd2, 32'hDEAD_BEEF, "rd_des_addr");
      do_write(3'd6, 3'd3, 32'h0000_0777);
      do_read(3'd6, 3'd3, 32'h0000_0777, "rd_des_size");
      do_write(3'd0, 3'd4, 32'hFFFF_FFFE);
      do_read(3'd0, 3'd4, 32'h0000_0002, "rd_status");
      do_write(3'd5, 3'd7, 32'h0000_1234);
      do_read(3'd5, 3'd7, 32'h0000_0000, "rd_profile_ro");
      // Read and write of the same field in the same cycle returns the old value.
      rd_q.push_back(32'h1000_0040);
      bus.wr_en = 1'b1; bus.wr_index = 3'd2; bus.wr_field = 3'd0; bus.wr_data = 32'hAAAA_5555;
      bus.rd_en = 1'b1; bus.rd_index = 3'd2; bus.rd_field = 3'd0;
      @(negedge clk);
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      held = rd_q.pop_front();
      n_checks++; if (bus.rd_data !== held) begin n_fail++; $display("FAIL rd_during_wr: got %h, expected %h", bus.rd_data, held); end
      do_read(3'd2, 3'd0, 32'hAAAA_5555, "rd_after_wr");
   endtask

   task automatic test_seq_two();
      int nseq;
      int extra = 0;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         do_write(3'(i), 3'd0, 32'h100 + 32'(i));
         do_write(3'(i), 3'd4, 32'd1);
      end
      iss_q.push_back(3'd0); iss_q.push_back(3'd1);
      bus.iss_ready = 1'b1;
      start_seq(3'd0);
      run_engine(5, 200, nseq);
      n_checks++; if (nseq != 1) begin n_fail++; $display("FAIL two_seq_done: got %0d, expected 1", nseq); end
      repeat (4) begin @(negedge clk); if (bus.seq_done === 1'b1) extra++; end
      n_checks++; if (extra != 0) begin n_fail++; $display("FAIL two_seq_done_once: got %0d extra pulses, expected 0", extra); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL two_busy_after: got %b, expected 0", bus.busy); end
      n_checks++; if (iss_q.size() != 0) begin n_fail++; $display("FAIL two_issue_count: got %0d missing, expected 0", iss_q.size()); end
      do_read(3'd0, 3'd4, 32'd3, "two_status0");
      do_read(3'd1, 3'd4, 32'd3, "two_status1");
      do_read(3'd2, 3'd4, 32'd0, "two_status2");
      do_read(3'd0, 3'd7, 32'd5, "two_profile0");
      do_read(3'd1, 3'd7, 32'd5, "two_profile1");
   endtask

   task automatic test_wrap();
      int nseq;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         do_write(3'(i), 3'd0, 32'h100 + 32'(i));
         do_write(3'(i), 3'd4, 32'd1);
      end
      iss_q.push_back(3'd6); iss_q.push_back(3'd7);
      for (int i = 0; i < 6; i++) iss_q.push_back(3'(i));
      start_seq(3'd6);
      run_engine(2, 400, nseq);
      n_checks++; if (nseq != 1) begin n_fail++; $display("FAIL wrap_seq_done: got %0d, expected 1", nseq); end
      n_checks++; if (iss_q.size() != 0) begin n_fail++; $display("FAIL wrap_issue_count: got %0d missing, expected 0", iss_q.size()); end
      do_read(3'd5, 3'd4, 32'd3, "wrap_status5");
      do_read(3'd6, 3'd7, 32'd2, "wrap_profile6");
   endtask

   task automatic test_wr_err();
      bit ok;
      bit seen = 1'b0;
      do_reset();
      do_write(3'd4, 3'd4, 32'd1);
      start_seq(3'd4);
      wait_issue(ok);
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_index = 3'd4; bus.wr_field = 3'd4; bus.wr_data = 32'd1;
      @(negedge clk);
      bus.wr_en = 1'b0;
      n_checks++; if (bus.wr_err !== 1'b1) begin n_fail++; $display("FAIL wr_err_pulse: got %b, expected 1", bus.wr_err); end
      @(negedge clk);
      n_checks++; if (bus.wr_err !== 1'b0) begin n_fail++; $display("FAIL wr_err_one_cycle: got %b, expected 0", bus.wr_err); end
      do_read(3'd4, 3'd4, 32'd2, "wr_err_status_running");
      bus.eng_done = 1'b1;
      @(negedge clk);
      bus.eng_done = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); if (bus.seq_done === 1'b1) seen = 1'b1; end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL wr_err_seq_done: got 0, expected 1"); end
      do_read(3'd4, 3'd4, 32'd3, "wr_err_status_done");
   endtask

   task automatic test_abort();
      bit ok;
      do_reset();
      do_write(3'd3, 3'd4, 32'd1);
      start_seq(3'd3);
      wait_issue(ok);
      repeat (3) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      n_checks++; if (bus.seq_done !== 1'b0) begin n_fail++; $display("FAIL abort_seq_done_early: got %b, expected 0", bus.seq_done); end
      @(negedge clk);
      n_checks++; if (bus.seq_done !== 1'b1) begin n_fail++; $display("FAIL abort_seq_done: got %b, expected 1", bus.seq_done); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, expected 0", bus.busy); end
      // A stray completion while idle must not touch the table.
      bus.eng_done = 1'b1;
      @(negedge clk);
      bus.eng_done = 1'b0;
      do_read(3'd3, 3'd4, 32'd1, "abort_status_ready");
      do_read(3'd3, 3'd7, 32'd0, "abort_profile");
   endtask

   task automatic test_reset_mid();
      bit ok;
      int seen = 0;
      do_reset();
      do_write(3'd1, 3'd4, 32'd1);
      start_seq(3'd1);
      wait_issue(ok);
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b, expected 1", bus.busy); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b, expected 0", bus.busy); end
      n_checks++; if (bus.iss_valid !== 1'b0) begin n_fail++; $display("FAIL mid_iss_valid: got %b, expected 0", bus.iss_valid); end
      repeat (5) begin @(negedge clk); if (bus.seq_done === 1'b1) seen++; end
      n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_no_seq_done: got %0d pulses, expected 0", seen); end
      for (int i = 0; i < 8; i++) do_read(3'(i), 3'd4, 32'd0, "mid_status");
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_index = '0; bus.wr_field = '0; bus.wr_data = '0;
      bus.rd_en = 1'b0; bus.rd_index = '0; bus.rd_field = '0;
      bus.start = 1'b0; bus.start_index = '0; bus.abort = 1'b0;
      bus.iss_ready = 1'b1; bus.eng_done = 1'b0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_seq_two();
      test_wrap();
      test_wr_err();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
